// File: rtl/carry_chain_serial_addsub_pkg.sv
// Shared types and sizing helpers for the slice-serial add/sub unit.
// State encoding and index width live here so top and bench agree.
package carry_chain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int data_w(input int slice_w, input int num_slices);
        return slice_w * num_slices;
    endfunction

    function automatic int idx_w(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/carry_chain_serial_addsub_if.sv
// Request/result handshake bundle for the slice-serial add/sub unit.
// master drives operands and out_ready; slave returns the result.
interface carry_chain_serial_addsub_if
    import carry_chain_pkg::*;
#(
    parameter int DATA_W = data_w(8, 4)
);
    logic              in_valid;
    logic              in_ready;
    logic              sub;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              cout;
    logic              ovf;

    modport master (
        output in_valid, sub, a, b, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, sub, a, b, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/carry_chain_serial_addsub_slice.sv
// One SLICE_W-bit ripple slice built from CARRY_CHAIN style cells.
// Each cell muxes carry: propagate passes cin, otherwise generate.
module carry_chain_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] p,
    input  logic [SLICE_W-1:0] g,
    input  logic               cin,
    output logic [SLICE_W-1:0] o,
    output logic               cout,
    output logic               c_msb_in
);
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_cell
        assign o[i]   = p[i] ^ c[i];
        assign c[i+1] = p[i] ? c[i] : g[i];
    end

    assign cout     = c[SLICE_W];
    assign c_msb_in = c[SLICE_W-1];
endmodule

// File: rtl/carry_chain_serial_addsub.sv
// Wide add/sub streamed LSB-slice-first through one narrow carry slice.
// Slice carry-out is registered and fed back as the next slice carry-in.
module carry_chain_serial_addsub
    import carry_chain_pkg::*;
#(
    parameter int SLICE_W    = 8,
    parameter int NUM_SLICES = 4
) (
    input logic clk,
    input logic rst_n,
    carry_chain_serial_addsub_if.slave bus
);
    localparam int DW = data_w(SLICE_W, NUM_SLICES);
    localparam int IW = idx_w(NUM_SLICES);
    localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   result_q, result_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic [SLICE_W-1:0] a_s, b_s, b_x, p, g, o;
    logic               s_cout, s_cmsb;

    // Constant-index select keeps the slice mux free of variable part-selects
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (idx_q == IW'(k)) begin
                a_s = a_q[k*SLICE_W +: SLICE_W];
                b_s = b_q[k*SLICE_W +: SLICE_W];
            end
        end
        b_x = b_s ^ {SLICE_W{sub_q}};
        p   = a_s ^ b_x;
        g   = a_s & b_x;
    end

    carry_chain_slice #(.SLICE_W(SLICE_W)) u_slice (
        .p        (p),
        .g        (g),
        .cin      (carry_q),
        .o        (o),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NUM_SLICES; k++) begin
                    if (idx_q == IW'(k)) begin
                        result_d[k*SLICE_W +: SLICE_W] = o;
                    end
                end
                carry_d = s_cout;
                if (idx_q == LAST) begin
                    cout_d  = s_cout;
                    ovf_d   = s_cmsb ^ s_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_carry_chain_serial_addsub.sv
// Self-checking bench: directed vector table, stall/reset sequences,
// and random back-to-back ops against an arithmetic reference model.
module tb_carry_chain_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    carry_chain_serial_addsub_if #(.DATA_W(32)) bus();

    carry_chain_serial_addsub #(
        .SLICE_W    (8),
        .NUM_SLICES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        v;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Reference: plain unsigned/signed arithmetic on the whole word
    function automatic exp_t model(input logic s, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [32:0] t;
        longint sa, sb, sum;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            e.r = a - b;
            e.c = (a >= b);
            sum = sa - sb;
        end else begin
            t   = {1'b0, a} + {1'b0, b};
            e.r = t[31:0];
            e.c = t[32];
            sum = sa + sb;
        end
        e.v = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
        return e;
    endfunction

    // Returns at the first negedge where out_valid is seen
    task automatic run_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b, input string tag,
                          output logic [31:0] r, output logic c,
                          output logic v, output int lat);
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b1;
        bus.sub = s;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) fail_now({tag, " out_valid"});
        r = bus.result;
        c = bus.cout;
        v = bus.ovf;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({tag, " result"}, 64'(bus.result), 64'(0));
        chk({tag, " cout"}, 64'(bus.cout), 64'(0));
        chk({tag, " ovf"}, 64'(bus.ovf), 64'(0));
    endtask

    vec_t vecs[9];
    exp_t q[$];

    initial begin
        logic [31:0] r;
        logic c, v;
        int lat;
        exp_t e;
        int pushed, got, cyc, last_acc;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i),
                   r, c, v, lat);
            chk($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].r));
            chk($sformatf("vec%0d cout", i), 64'(c), 64'(vecs[i].c));
            chk($sformatf("vec%0d ovf", i), 64'(v), 64'(vecs[i].v));
            if (i == 0) chk("latency", 64'(lat), 64'(5));
        end

        // Stall in DONE while a new request is waiting
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_op(1'b0, 32'h1111_1111, 32'h2222_2222, "stall", r, c, v, lat);
        bus.in_valid = 1'b1;
        bus.sub = 1'b0;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall out_valid", 64'(bus.out_valid), 64'(1));
            chk("stall result", 64'(bus.result), 64'h3333_3333);
            chk("stall in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release out_valid", 64'(bus.out_valid), 64'(0));
        chk("release in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) fail_now("after stall out_valid");
        chk("after stall result", 64'(bus.result), 64'hDEAD_BEF0);
        chk("after stall cout", 64'(bus.cout), 64'(0));

        // Reset pulse while slice 2 is being processed
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sub = 1'b0;
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrun reset");
        @(negedge clk);
        chk("held reset out_valid", 64'(bus.out_valid), 64'(0));
        rst_n = 1'b1;
        run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, "post reset", r, c, v, lat);
        chk("post reset result", 64'(r), 64'h0000_0100);
        chk("post reset cout", 64'(c), 64'(0));
        chk("post reset ovf", 64'(v), 64'(0));

        // Back-to-back random ops with both handshakes held high
        pushed = 0;
        got = 0;
        cyc = 0;
        last_acc = -1;
        bus.in_valid = 1'b1;
        while (got < 100 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    fail_now("rand unexpected out_valid");
                end else begin
                    e = q.pop_front();
                    chk("rand result", 64'(bus.result), 64'(e.r));
                    chk("rand cout", 64'(bus.cout), 64'(e.c));
                    chk("rand ovf", 64'(bus.ovf), 64'(e.v));
                    got++;
                end
            end
            if (bus.in_ready) begin
                if (pushed < 100) begin
                    bus.sub = 1'($urandom_range(0, 1));
                    bus.a = $urandom;
                    bus.b = $urandom;
                    q.push_back(model(bus.sub, bus.a, bus.b));
                    if (last_acc >= 0)
                        chk("rand interval", 64'(cyc - last_acc), 64'(6));
                    last_acc = cyc;
                    pushed++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (got < 100) fail_now("rand completion");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
